// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit operation codes, the illegal-op predicate and
// the requester-index width helper used by the ALU arbiter slice.
package alu_pkg;

    localparam logic [3:0] ALU_MOV = 4'b0000;
    localparam logic [3:0] ALU_NOT = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_LI  = 4'b1001;
    localparam logic [3:0] ALU_LUI = 4'b1010;
    localparam logic [3:0] ALU_JMP = 4'b1011;
    localparam logic [3:0] ALU_JAL = 4'b1100;
    localparam logic [3:0] ALU_LW  = 4'b1101;
    localparam logic [3:0] ALU_SW  = 4'b1110;

    // 1000 and 1111 are unassigned encodings.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == 4'b1000) || (op == 4'b1111);
    endfunction

    function automatic int calc_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU; add/sub wrap, SLT is signed, LI/LUI merge
// half-words, jump ops pass B and load/store ops form A+B addresses.
module alu
    import alu_pkg::*;
#(
    parameter int word_size = 32
) (
    input  logic [word_size-1:0] a,
    input  logic [word_size-1:0] b,
    input  logic [3:0]           op,
    output logic [word_size-1:0] y
);

    localparam int HALF = word_size / 2;

    logic lt;

    assign lt = $signed(a) < $signed(b);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        y = '0;
        case (op)
            ALU_MOV: y = a;
            ALU_NOT: y = ~a;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_OR:  y = a | b;
            ALU_AND: y = a & b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = {{(word_size-1){1'b0}}, lt};
            ALU_LI:  y = {a[word_size-1:HALF], b[HALF-1:0]};
            ALU_LUI: y = {b[HALF-1:0], a[HALF-1:0]};
            ALU_JMP: y = b;
            ALU_JAL: y = b;
            ALU_LW:  y = a + b;
            ALU_SW:  y = a + b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 (mod N) and grants
// the first asserted request; the pointer register is owned by the caller.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = calc_idw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (en && !found && req[i] && (i == (int'(ptr) + k) % N)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ valid/ready requesters with round-robin grant and
// a one-entry registered response buffer.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int WORD = 32,
    parameter  int NREQ = 2,
    localparam int IDW  = calc_idw(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [WORD*NREQ-1:0] req_a,
    input  logic [WORD*NREQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [WORD-1:0]      rsp_data,
    output logic                 rsp_err
);

    logic            free;
    logic            accept;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_idx;
    logic [3:0]      sel_op;
    logic [WORD-1:0] sel_a;
    logic [WORD-1:0] sel_b;
    logic [WORD-1:0] alu_y;
    logic            res_err;
    logic [WORD-1:0] res_data;

    assign free = !rsp_valid || rsp_ready;

    // Gating with rst_n keeps req_ready low while reset is held.
    rr_arbiter #(.N(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .en  (free && rst_n),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        gnt_idx = '0;
        sel_op  = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDW'(i);
                sel_op  = req_op[4*i +: 4];
                sel_a   = req_a[WORD*i +: WORD];
                sel_b   = req_b[WORD*i +: WORD];
            end
        end
    end

    alu #(.word_size(WORD)) u_alu (
        .a  (sel_a),
        .b  (sel_b),
        .op (sel_op),
        .y  (alu_y)
    );

    assign res_err  = is_illegal_op(sel_op);
    assign res_data = res_err ? '0 : alu_y;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            ptr       <= IDW'(NREQ - 1);
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_data  <= res_data;
            rsp_err   <= res_err;
            ptr       <= gnt_idx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
